// File: rtl/t_counter_pkg.sv
// t_counter_pkg: state encoding shared by the T flip-flop counter sequencer
package t_counter_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/t_ff_bank.sv
// t_ff_bank: WIDTH toggle flip-flops with asynchronous active-low reset
module t_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb q_d = q_q ^ T;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) q_q <= '0;
        else      q_q <= q_d;
    end
    assign Q = q_q;
endmodule

// File: rtl/t_counter_sequencer.sv
// t_counter_sequencer: FSM computing per-bit toggles to load/clear/count a T flip-flop register
module t_counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             UP,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE
);
    import t_counter_pkg::*;
    state_t state_q, state_d;
    logic [WIDTH-1:0] t, up_t, dn_t;
    // a bit toggles when all lower bits are about to carry (up) or borrow (down)
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tv
        assign up_t[i] = &Q[i-1:0];
        assign dn_t[i] = &(~Q[i-1:0]);
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        t = '0;
        if (CLEAR) begin
            t = Q;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (LOAD) t = Q ^ LOAD_VAL;
                    else if (START) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (Q == LIMIT) state_d = ST_DONE;
                    else if (STOP) state_d = ST_PAUSE;
                    else t = UP ? up_t : dn_t;
                end
                ST_PAUSE: begin
                    if (LOAD) t = Q ^ LOAD_VAL;
                    else if (START && !STOP) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (LOAD) t = Q ^ LOAD_VAL;
                end
            endcase
        end
    end
    always_comb begin
        BUSY = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        DONE = (state_q == ST_DONE);
    end
    t_ff_bank #(.WIDTH(WIDTH)) u_bank (
        .CLK(CLK),
        .RST(RST),
        .T  (t),
        .Q  (Q)
    );
endmodule

// File: tb/tb_t_counter_sequencer.sv
// tb_t_counter_sequencer: directed vector table plus hand sequences for pause, start-at-limit and async reset
module tb_t_counter_sequencer;
    localparam int W = 4;
    logic CLK = 1'b0, RST = 1'b0;
    logic START = 1'b0, STOP = 1'b0, CLEAR = 1'b0, LOAD = 1'b0, UP = 1'b0;
    logic [W-1:0] LOAD_VAL = '0, LIMIT = '0;
    logic [W-1:0] Q;
    logic BUSY, DONE;
    int total = 0, bad = 0;

    typedef struct {
        logic s, p, c, l, u;
        logic [3:0] lv, lim, q;
        logic b, d;
    } vec_t;
    vec_t vecs[$];

    t_counter_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .UP(UP), .LIMIT(LIMIT),
        .Q(Q), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic s, p, c, l, u, input logic [3:0] lv, lim, q, input logic b, d);
        vec_t v;
        v.s = s; v.p = p; v.c = c; v.l = l; v.u = u;
        v.lv = lv; v.lim = lim; v.q = q; v.b = b; v.d = d;
        return v;
    endfunction

    task automatic drive(input logic s, p, c, l, u, input logic [3:0] lv, lim);
        START = s; STOP = p; CLEAR = c; LOAD = l; UP = u; LOAD_VAL = lv; LIMIT = lim;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] q, input logic b, d);
        chk({nm, "_q"}, 32'(Q), 32'(q));
        chk({nm, "_busy"}, 32'(BUSY), 32'(b));
        chk({nm, "_done"}, 32'(DONE), 32'(d));
    endtask

    initial begin
        // load 3, count up to 7
        vecs.push_back(mk(0,0,0,1,0, 3, 0,  3,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0, 7,  3,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  4,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  5,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  6,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  7,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  7,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0, 7,  7,0,0));
        // down through zero to 14
        vecs.push_back(mk(0,0,0,1,0, 1, 0,  1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,14,  1,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,14,  0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,14, 15,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,14, 14,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,14, 14,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,14, 14,0,0));
        // up from 15 wraps to 0, stops at 1
        vecs.push_back(mk(0,0,0,1,0,15, 0, 15,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0, 1, 15,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 1,  0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 1,  1,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 1,  1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0, 1,  1,0,0));
        // LOAD ignored in RUN; STOP loses to limit
        vecs.push_back(mk(0,0,0,1,0, 0, 0,  0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,12,  0,1,0));
        vecs.push_back(mk(0,0,0,1,1, 9,12,  1,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,12,  2,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0, 3,  3,1,0));
        vecs.push_back(mk(0,1,0,0,1, 0, 3,  3,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0, 3,  3,0,0));
        // CLEAR beats LOAD in RUN, no DONE afterwards
        vecs.push_back(mk(0,0,0,1,1, 8,15,  8,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,15,  8,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,15,  9,1,0));
        vecs.push_back(mk(0,0,1,1,1, 5,15,  0,0,0));
        vecs.push_back(mk(0,0,0,0,1, 0,15,  0,0,0));

        tick;
        tick;
        chk_out("reset", 0, 0, 0);
        RST = 1'b1;
        tick;
        chk_out("post_reset_idle", 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].l, vecs[i].u, vecs[i].lv, vecs[i].lim);
            tick;
            chk_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].d);
        end

        // pause / resume
        drive(0,0,0,1,1, 4,15); tick; chk_out("pz_load", 4, 0, 0);
        drive(1,0,0,0,1, 0,15); tick; chk_out("pz_start", 4, 1, 0);
        drive(0,0,0,0,1, 0,15); tick; chk_out("pz_cnt", 5, 1, 0);
        drive(0,1,0,0,1, 0,15); tick; chk_out("pz_stop", 5, 1, 0);
        drive(0,0,0,0,1, 0,15);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk_out($sformatf("pz_hold%0d", k), 5, 1, 0);
        end
        drive(0,0,0,1,1, 9,15); tick; chk_out("pz_load9", 9, 1, 0);
        drive(1,1,0,0,1, 0,15); tick; chk_out("pz_both", 9, 1, 0);
        drive(0,0,0,0,1, 0,15); tick; chk_out("pz_still", 9, 1, 0);
        drive(1,0,0,0,1, 0,15); tick; chk_out("pz_resume", 9, 1, 0);
        drive(0,0,0,0,1, 0,15); tick; chk_out("pz_cnt10", 10, 1, 0);
        drive(0,0,1,0,1, 0,15); tick; chk_out("pz_clear", 0, 0, 0);

        // start while already at limit
        drive(0,0,0,1,1, 7, 7); tick; chk_out("lim_load", 7, 0, 0);
        drive(1,0,0,0,1, 0, 7); tick; chk_out("lim_run", 7, 1, 0);
        drive(0,0,0,0,1, 0, 7); tick; chk_out("lim_done", 7, 0, 1);
        tick; chk_out("lim_idle", 7, 0, 0);

        // asynchronous reset mid-count
        drive(0,0,0,1,1, 3,15); tick; chk_out("rst_load", 3, 0, 0);
        drive(1,0,0,0,1, 0,15); tick; chk_out("rst_start", 3, 1, 0);
        drive(0,0,0,0,1, 0,15);
        for (int k = 4; k <= 6; k++) begin
            tick;
            chk_out($sformatf("rst_cnt%0d", k), 4'(k), 1, 0);
        end
        #2 RST = 1'b0;
        #1 chk_out("rst_async", 0, 0, 0);
        tick; chk_out("rst_held", 0, 0, 0);
        @(negedge CLK) RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_out($sformatf("rst_idle%0d", k), 0, 0, 0);
        end
        drive(1,0,0,0,1, 0,15); tick; chk_out("rst_restart", 0, 1, 0);
        drive(0,0,0,0,1, 0,15); tick; chk_out("rst_recount", 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
